msf_frame_encoder: RTL and testbench
====================================

// Module: msf_frame_encoder
// PURPOSE
//  MSF time-code transmitter: converts BCD hh:mm into the 60 s MSF carrier on/off pattern.
//  Drives a local test emitter or the receiver-side bench.
//  Inverse of the clock's decode/load path; time_i uses the same packing as the upper
//  13 bits of the hh:mm:ss digit-chain load word.
//  Advances on a 10 Hz tick; optionally auto-increments the minute for free-running operation.
// PARAMETERS
//  AUTO_INC  1  1: latched time +1 minute at each frame wrap; 0: re-latch time_i at each wrap
// PORTS
//  clk_i      in   1   system clock
//  rst_i      in   1   reset; synchronous, active-high
//  tick_i     in   1   1-cycle strobe every 100 ms
//  start_i    in   1   begin transmission (ignored while busy_o=1)
//  stop_i     in   1   abort transmission
//  time_i     in   13  {hr_t[1:0], hr_u[3:0], mn_t[2:0], mn_u[3:0]} BCD
//  carrier_o  out  1   1 = carrier on, 0 = carrier off
//  busy_o     out  1   frame transmission in progress
//  sec_o      out  6   current second of frame, 0..59
//  frame_o    out  1   1-cycle pulse at start of each second-0 (minute marker)
// BEHAVIOUR
//  Reset values
//   - carrier_o=1, busy_o=0, sec_o=0, frame_o=0; tenth counter=0.
//  States
//   - IDLE: carrier_o=1; counters held at 0.
//   - RUN: transmitting.
//  Transitions
//   - IDLE + start_i -> RUN: latch time_i; position=(sec 0, tenth 0).
//     On the next cycle: carrier_o=0, busy_o=1, frame_o=1.
//   - RUN + stop_i -> IDLE next cycle, outputs at reset values. stop_i wins over tick_i.
//  Advancing (RUN, on each tick_i)
//   - Registered outputs update the cycle after tick_i.
//   - tenth++; tenth 9 -> 0 and sec++; sec 59 -> 0 is a frame wrap.
//  Frame wrap
//   - AUTO_INC=1: minute +1 in BCD. mn_u 9->0 carries to mn_t; mn_t 5->0 carries to hour.
//     Hours roll 23:59 -> 00:00; hr_u 9->0 with hr_t+1.
//   - AUTO_INC=0: re-latch time_i.
//   - frame_o pulses 1 cycle.
//  Carrier pattern per second s, tenth t (0 = off)
//   - s=0: off for t=0..4, on for t=5..9.
//   - s>0: t=0 off; t=1 off iff A[s]; t=2 off iff B[s]; t=3..9 on.
//  A bits
//   - 1..16, 17..38 (year/month/day/dow): all 0.
//   - 39..44: hour (20,10,8,4,2,1).
//   - 45..51: minute (40,20,10,8,4,2,1).
//   - 52..59: 0,1,1,1,1,1,1,0.
//  B bits
//   - 0 except 54B=55B=56B=1 (odd parity over the zero fields).
//   - 57B = odd parity over A39..A51: set so ones(A39..51)+57B is odd.
//   - 58B = 0 (GMT).
//  Widths and edge cases
//   - No range check on time_i digits: bit patterns are sent verbatim.
//   - Auto-increment uses >= comparisons, so any invalid digit wraps to 0.
//   - start_i while busy_o=1 is ignored; tick_i in IDLE is ignored.
//   - start_i and stop_i together in IDLE: start honoured.
//   - Reset mid-frame returns to IDLE within one cycle.
// TESTING
//  1. Reset, no start, 20 ticks -> carrier_o=1, busy_o=0, sec_o=0 throughout.
//  2. start_i with time 12:34, AUTO_INC=0 -> frame_o=1; carrier_o off exactly 5 ticks in s0.
//     s1..s16: each off 1 tick.
//  3. Same frame -> s39..44 A=010010; s45..51 A=0110100; 57B=0; s52..59 A=01111110.
//     54B..56B=1: s54..56 off for 3 ticks.
//  4. AUTO_INC=1, start at 23:59 -> after 600 ticks the second frame encodes 00:00.
//     s39..51 all 1-tick offs; 57B=1.
//  5. stop_i asserted at s30 t4 -> next cycle carrier_o=1, busy_o=0, sec_o=0.
//     A later start_i restarts at s0.
//  6. rst_i asserted during s47 -> next cycle all outputs at reset values.
//     start_i during the run is ignored, frame unchanged.

Source files
------------

// File: rtl/msf_frame_encoder_if.sv
// Bus between the MSF frame encoder and whatever drives its tick/control/time inputs.
// The master side supplies tick, start/stop and the BCD time; the slave side returns carrier and status.
interface msf_frame_encoder_if;
  logic        tick_i;
  logic        start_i;
  logic        stop_i;
  logic [12:0] time_i;
  logic        carrier_o;
  logic        busy_o;
  logic [5:0]  sec_o;
  logic        frame_o;

  modport master (
    output tick_i, start_i, stop_i, time_i,
    input  carrier_o, busy_o, sec_o, frame_o
  );

  modport slave (
    input  tick_i, start_i, stop_i, time_i,
    output carrier_o, busy_o, sec_o, frame_o
  );
endinterface

// File: rtl/msf_frame_encoder.sv
// MSF time-code transmitter: walks a 60 s frame in 100 ms steps and keys the carrier
// from the latched BCD hh:mm. Optionally advances the minute at every frame wrap.
//
//   state | meaning
//   IDLE  | carrier on, position held at s0 t0, waiting for start
//   RUN   | transmitting; position advances on tick
module msf_frame_encoder #(
  parameter bit AUTO_INC = 1'b1
) (
  input logic clk_i,
  input logic rst_i,
  msf_frame_encoder_if.slave bus
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state;
  logic [3:0]  tenth;
  logic [5:0]  sec;
  logic [12:0] tm;

  logic [3:0]  tenth_nx;
  logic [5:0]  sec_nx;
  logic        wrap;
  logic [12:0] tm_inc;
  logic [12:0] tm_wrap;

  logic [1:0] hr_t;
  logic [3:0] hr_u;
  logic [2:0] mn_t;
  logic [3:0] mn_u;

  assign {hr_t, hr_u, mn_t, mn_u} = tm;

  always_comb begin
    wrap     = 1'b0;
    tenth_nx = tenth + 4'd1;
    sec_nx   = sec;
    if (tenth >= 4'd9) begin
      tenth_nx = 4'd0;
      if (sec >= 6'd59) begin
        sec_nx = 6'd0;
        wrap   = 1'b1;
      end else begin
        sec_nx = sec + 6'd1;
      end
    end
  end

  // >= compares make any out-of-range digit fall back to 0 on the next increment
  always_comb begin
    tm_inc = tm;
    if (mn_u < 4'd9) begin
      tm_inc[3:0] = mn_u + 4'd1;
    end else begin
      tm_inc[3:0] = 4'd0;
      if (mn_t < 3'd5) begin
        tm_inc[6:4] = mn_t + 3'd1;
      end else begin
        tm_inc[6:4] = 3'd0;
        if (hr_t >= 2'd2 && hr_u >= 4'd3) begin
          tm_inc[12:7] = 6'd0;
        end else if (hr_u < 4'd9) begin
          tm_inc[10:7] = hr_u + 4'd1;
        end else begin
          tm_inc[10:7]  = 4'd0;
          tm_inc[12:11] = hr_t + 2'd1;
        end
      end
    end
    tm_wrap = AUTO_INC ? tm_inc : bus.time_i;
  end

  // A39..A51 map straight onto time bits 12..0
  function automatic logic carrier_at(input logic [5:0] s, input logic [3:0] t,
                                      input logic [12:0] code);
    logic       a;
    logic       b;
    logic       on;
    logic [5:0] idx;
    a   = 1'b0;
    b   = 1'b0;
    idx = 6'd51 - s;
    if (s >= 6'd39 && s <= 6'd51)      a = code[idx[3:0]];
    else if (s >= 6'd53 && s <= 6'd58) a = 1'b1;
    if (s >= 6'd54 && s <= 6'd56)      b = 1'b1;
    else if (s == 6'd57)               b = ~(^code);
    if (s == 6'd0)       on = (t >= 4'd5);
    else if (t == 4'd0)  on = 1'b0;
    else if (t == 4'd1)  on = ~a;
    else if (t == 4'd2)  on = ~b;
    else                 on = 1'b1;
    return on;
  endfunction

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state         <= IDLE;
      tenth         <= 4'd0;
      sec           <= 6'd0;
      tm            <= 13'd0;
      bus.carrier_o <= 1'b1;
      bus.busy_o    <= 1'b0;
      bus.sec_o     <= 6'd0;
      bus.frame_o   <= 1'b0;
    end else begin
      bus.frame_o <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start_i) begin
            state         <= RUN;
            tm            <= bus.time_i;
            tenth         <= 4'd0;
            sec           <= 6'd0;
            bus.carrier_o <= 1'b0;
            bus.busy_o    <= 1'b1;
            bus.sec_o     <= 6'd0;
            bus.frame_o   <= 1'b1;
          end
        end
        RUN: begin
          if (bus.stop_i) begin
            state         <= IDLE;
            tenth         <= 4'd0;
            sec           <= 6'd0;
            bus.carrier_o <= 1'b1;
            bus.busy_o    <= 1'b0;
            bus.sec_o     <= 6'd0;
          end else if (bus.tick_i) begin
            tenth         <= tenth_nx;
            sec           <= sec_nx;
            bus.sec_o     <= sec_nx;
            bus.carrier_o <= carrier_at(sec_nx, tenth_nx, wrap ? tm_wrap : tm);
            if (wrap) begin
              tm          <= tm_wrap;
              bus.frame_o <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_msf_frame_encoder.sv
// Bench for msf_frame_encoder: one instance per AUTO_INC setting, shared stimulus,
// each checked every cycle against a decimal-time / tenth-index reference model.
module tb_msf_frame_encoder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        tick  = 1'b0;
  logic        start = 1'b0;
  logic        stop  = 1'b0;
  logic [12:0] tm    = 13'd0;

  msf_frame_encoder_if bus0 ();
  msf_frame_encoder_if bus1 ();

  assign bus0.tick_i  = tick;
  assign bus0.start_i = start;
  assign bus0.stop_i  = stop;
  assign bus0.time_i  = tm;
  assign bus1.tick_i  = tick;
  assign bus1.start_i = start;
  assign bus1.stop_i  = stop;
  assign bus1.time_i  = tm;

  msf_frame_encoder #(.AUTO_INC(1'b0)) dut0 (.clk_i(clk), .rst_i(rst), .bus(bus0.slave));
  msf_frame_encoder #(.AUTO_INC(1'b1)) dut1 (.clk_i(clk), .rst_i(rst), .bus(bus1.slave));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d want=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [12:0] enc(input int h, input int m);
    logic [12:0] r;
    r[12:11] = 2'(h / 10);
    r[10:7]  = 4'(h % 10);
    r[6:4]   = 3'(m / 10);
    r[3:0]   = 4'(m % 10);
    return r;
  endfunction

  function automatic int dec_h(input logic [12:0] c);
    return int'(c[12:11]) * 10 + int'(c[10:7]);
  endfunction

  function automatic int dec_m(input logic [12:0] c);
    return int'(c[6:4]) * 10 + int'(c[3:0]);
  endfunction

  // A-bit of second s from the weighted-field definition (greedy decimal weights)
  function automatic bit a_bit(input int s, input int h, input int m);
    int w[13];
    int r;
    bit b;
    w = '{20, 10, 8, 4, 2, 1, 40, 20, 10, 8, 4, 2, 1};
    b = 1'b0;
    if (s >= 39 && s <= 44) begin
      r = h;
      for (int i = 39; i <= s; i++) begin
        b = (r >= w[i-39]);
        if (b) r -= w[i-39];
      end
    end else if (s >= 45 && s <= 51) begin
      r = m;
      for (int i = 45; i <= s; i++) begin
        b = (r >= w[i-39]);
        if (b) r -= w[i-39];
      end
    end else if (s >= 53 && s <= 58) begin
      b = 1'b1;
    end
    return b;
  endfunction

  function automatic bit b_bit(input int s, input int h, input int m);
    int ones;
    if (s >= 54 && s <= 56) return 1'b1;
    if (s == 57) begin
      ones = 0;
      for (int i = 39; i <= 51; i++) ones += int'(a_bit(i, h, m));
      return (ones % 2) == 0;
    end
    return 1'b0;
  endfunction

  function automatic bit exp_carrier(input int p, input int h, input int m);
    int s;
    int t;
    s = p / 10;
    t = p % 10;
    if (s == 0) return t >= 5;
    if (t == 0) return 1'b0;
    if (t == 1) return !a_bit(s, h, m);
    if (t == 2) return !b_bit(s, h, m);
    return 1'b1;
  endfunction

  bit run[2]     = '{1'b0, 1'b0};
  int pos[2]     = '{0, 0};
  int hh[2]      = '{0, 0};
  int mm[2]      = '{0, 0};
  bit e_frame[2] = '{1'b0, 1'b0};

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      e_frame[k] = 1'b0;
      if (rst) begin
        run[k] = 1'b0;
        pos[k] = 0;
      end else if (!run[k]) begin
        if (start) begin
          run[k]     = 1'b1;
          pos[k]     = 0;
          hh[k]      = dec_h(tm);
          mm[k]      = dec_m(tm);
          e_frame[k] = 1'b1;
        end
      end else if (stop) begin
        run[k] = 1'b0;
        pos[k] = 0;
      end else if (tick) begin
        pos[k] = (pos[k] + 1) % 600;
        if (pos[k] == 0) begin
          e_frame[k] = 1'b1;
          if (k == 1) begin
            int mins;
            mins  = (hh[k] * 60 + mm[k] + 1) % 1440;
            hh[k] = mins / 60;
            mm[k] = mins % 60;
          end else begin
            hh[k] = dec_h(tm);
            mm[k] = dec_m(tm);
          end
        end
      end
    end
  end

  function automatic bit exp_car(input int k);
    return run[k] ? exp_carrier(pos[k], hh[k], mm[k]) : 1'b1;
  endfunction

  function automatic int exp_sec(input int k);
    return run[k] ? pos[k] / 10 : 0;
  endfunction

  task automatic compare_all();
    chk("carrier0", 32'(bus0.carrier_o), 32'(exp_car(0)));
    chk("busy0",    32'(bus0.busy_o),    32'(run[0]));
    chk("sec0",     32'(bus0.sec_o),     32'(exp_sec(0)));
    chk("frame0",   32'(bus0.frame_o),   32'(e_frame[0]));
    chk("carrier1", 32'(bus1.carrier_o), 32'(exp_car(1)));
    chk("busy1",    32'(bus1.busy_o),    32'(run[1]));
    chk("sec1",     32'(bus1.sec_o),     32'(exp_sec(1)));
    chk("frame1",   32'(bus1.frame_o),   32'(e_frame[1]));
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
    compare_all();
    tick  = 1'b0;
    start = 1'b0;
    stop  = 1'b0;
  endtask

  task automatic tick_pulse();
    repeat ($urandom_range(0, 2)) cyc();
    tick = 1'b1;
    cyc();
  endtask

  task automatic tick_to(input int target, input string tag);
    int budget;
    budget = 700;
    while (pos[0] != target && budget > 0) begin
      tick_pulse();
      budget--;
    end
    chk(tag, 32'(pos[0]), 32'(target));
  endtask

  int off_s0;
  int off_57;
  int off_mid;

  initial begin
    repeat (3) cyc();
    rst = 1'b0;
    chk("rst_busy",    32'(bus0.busy_o),    32'd0);
    chk("rst_carrier", 32'(bus1.carrier_o), 32'd1);

    // idle ticks do nothing
    repeat (20) tick_pulse();

    // 12:34; dut0 re-latches a new time at the wrap, dut1 increments
    tm    = enc(12, 34);
    start = 1'b1;
    cyc();
    chk("start_frame", 32'(bus0.frame_o), 32'd1);
    off_s0 = (bus0.carrier_o == 1'b0) ? 1 : 0;
    for (int i = 0; i < 630; i++) begin
      if (i == 200) start = 1'b1;
      if (i == 300) tm = enc(7, 5);
      tick = 1'b1;
      cyc();
      if (i < 599 && pos[0] < 10 && bus0.carrier_o == 1'b0) off_s0++;
      repeat ($urandom_range(0, 1)) cyc();
    end
    chk("s0_off_ticks", 32'(off_s0), 32'd5);

    tick_to(304, "reach_s30t4");
    stop = 1'b1;
    tick = 1'b1;
    cyc();
    chk("stop_busy", 32'(bus0.busy_o), 32'd0);
    chk("stop_sec",  32'(bus1.sec_o),  32'd0);
    repeat (5) tick_pulse();

    // 23:59 with increment: second frame must encode 00:00
    tm    = enc(23, 59);
    start = 1'b1;
    cyc();
    repeat (600) tick_pulse();
    off_57  = 0;
    off_mid = 0;
    for (int i = 0; i < 600; i++) begin
      tick_pulse();
      if (pos[1] >= 570 && pos[1] <= 579 && bus1.carrier_o == 1'b0) off_57++;
      if (pos[1] >= 390 && pos[1] <= 519 && bus1.carrier_o == 1'b0) off_mid++;
    end
    chk("s57_off_ticks",    32'(off_57),  32'd3);
    chk("s39_51_off_ticks", 32'(off_mid), 32'd13);

    // start during run ignored, then reset during s47
    tick_to(230, "reach_s23");
    start = 1'b1;
    tm    = enc(1, 1);
    tick  = 1'b1;
    cyc();
    tick_to(475, "reach_s47");
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("rst_mid_busy",  32'(bus1.busy_o),    32'd0);
    chk("rst_mid_car",   32'(bus0.carrier_o), 32'd1);

    // randomized control mix
    for (int i = 0; i < 4000; i++) begin
      tick  = ($urandom_range(0, 2) == 0);
      start = ($urandom_range(0, 49) == 0);
      stop  = ($urandom_range(0, 299) == 0);
      rst   = ($urandom_range(0, 999) == 0);
      if ($urandom_range(0, 99) == 0)
        tm = enc($urandom_range(0, 23), $urandom_range(0, 59));
      cyc();
    end
    rst = 1'b0;
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
